tt_um_drum_goekce: RTL and testbench

Tiny Tapeout top-level wrapping a DRUM (Dynamic Range Unbiased Multiplier) approximate multiplier. Two unsigned operands arrive on `ui_in`; the approximate product appears combinationally on `uo_out`. A small on-chip byte RAM logs products on command and can be read back through the same output port. The block sits directly under the Tiny Tapeout harness.

---
 rtl/drum_pkg.sv | 8 +
 rtl/drum_mult.sv | 39 +++
 rtl/tt_um_drum_goekce.sv | 58 +++++
 tb/tb_tt_um_drum_goekce.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/drum_pkg.sv
// drum_pkg: default DRUM parameters shared by the multiplier and the top level
package drum_pkg;
    localparam int DRUM_K         = 3;
    localparam int DRUM_N         = 4;
    localparam int DRUM_M         = 4;
    localparam int DRUM_RAM_BYTES = 32;
    localparam int DRUM_AW        = $clog2(DRUM_RAM_BYTES);
endpackage

// File: rtl/drum_mult.sv
// drum_mult: combinational DRUM approximate multiplier (truncate to k bits, force LSB, shift back)
module drum_mult
    import drum_pkg::*;
#(
    parameter int k = DRUM_K,
    parameter int n = DRUM_N,
    parameter int m = DRUM_M
) (
    input  logic [n-1:0]   i_a,
    input  logic [m-1:0]   i_b,
    output logic [n+m-1:0] o_p
);
    localparam int W  = (n > m) ? n : m;
    localparam int SW = $clog2(W + 1);
    localparam int PW = n + m;

    function automatic void approx(input logic [W-1:0] x, output logic [k-1:0] t, output logic [SW-1:0] s);
        int p;
        int sh;
        logic [W-1:0] sx;
        p = 0;
        for (int i = 0; i < W; i++) if (x[i]) p = i;
        sh = (p < k) ? 0 : p - k + 1;
        sx = x >> sh;
        t  = (p < k) ? x[k-1:0] : {sx[k-1:1], 1'b1};
        s  = SW'(sh);
    endfunction

    logic [k-1:0]  w_ta, w_tb;
    logic [SW-1:0] w_sa, w_sb;

    // segment both operands; small values pass through exactly
    always_comb begin
        approx(W'(i_a), w_ta, w_sa);
        approx(W'(i_b), w_tb, w_sb);
    end

    assign o_p = (PW'(w_ta) * PW'(w_tb)) << ({1'b0, w_sa} + {1'b0, w_sb});
endmodule

// File: rtl/tt_um_drum_goekce.sv
// tt_um_drum_goekce: Tiny Tapeout wrapper with DRUM multiplier and a product log RAM
module tt_um_drum_goekce
    import drum_pkg::*;
#(
    parameter int k         = DRUM_K,
    parameter int n         = DRUM_N,
    parameter int m         = DRUM_M,
    parameter int RAM_BYTES = DRUM_RAM_BYTES
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);
    localparam int AW = $clog2(RAM_BYTES);
    localparam int PW = n + m;

    logic [PW-1:0] w_prod;
    logic [PW-1:0] r_ram [RAM_BYTES];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] w_rd_addr;
    logic          w_store, w_clr, w_read, w_unused;

    assign w_store   = uio_in[5];
    assign w_clr     = uio_in[6];
    assign w_read    = uio_in[7];
    assign w_rd_addr = uio_in[AW-1:0];
    assign w_unused  = &{1'b0, ena, ui_in, uio_in};
    assign uio_out   = '0;
    assign uio_oe    = '0;

    drum_mult #(.k(k), .n(n), .m(m)) u_mult (
        .i_a(ui_in[n-1:0]),
        .i_b(ui_in[n+m-1:n]),
        .o_p(w_prod)
    );

    // log products at the write pointer; the pin named rst_n is an active-high reset
    always_ff @(posedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < RAM_BYTES; i++) r_ram[i] <= '0;
            r_wptr <= '0;
        end else begin
            if (w_store) r_ram[r_wptr] <= w_prod;
            if (w_clr) r_wptr <= '0;
            else if (w_store) r_wptr <= (r_wptr == AW'(RAM_BYTES - 1)) ? '0 : r_wptr + 1'b1;
        end
    end

    // output either the live product or a log entry; addresses past the log read as zero
    always_comb begin
        uo_out = w_read ? ((int'(w_rd_addr) < RAM_BYTES) ? 8'(r_ram[w_rd_addr]) : 8'h00) : 8'(w_prod);
    end
endmodule

// File: tb/tb_tt_um_drum_goekce.sv
// tb_tt_um_drum_goekce: directed and random checks of the DRUM wrapper against an arithmetic model
module tb_tt_um_drum_goekce;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic [7:0] ui_in = '0;
    logic [7:0] uio_in = '0;
    logic [7:0] uo_out, uio_out, uio_oe;

    int nchk = 0;
    int nfail = 0;
    int mem [32];
    int wp = 0;

    always #5 clk = ~clk;

    tt_um_drum_goekce dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uo_out(uo_out),
        .uio_in(uio_in), .uio_out(uio_out), .uio_oe(uio_oe)
    );

    function automatic int approx(int x);
        int p, s;
        if (x < 8) return x;
        p = 0;
        while ((1 << (p + 1)) <= x) p++;
        s = p - 2;
        return ((x >> s) | 1) << s;
    endfunction

    function automatic int ref_p(int a, int b);
        return approx(a) * approx(b);
    endfunction

    task automatic chk(string tag, logic [7:0] got, logic [7:0] exp);
        nchk++;
        assert (got === exp) else begin
            nfail++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic prod(int a, int b, int exp);
        ui_in = {4'(b), 4'(a)};
        uio_in = '0;
        #1;
        chk($sformatf("prod %0d*%0d", a, b), uo_out, 8'(exp));
    endtask

    task automatic rd(int addr, int exp);
        uio_in = {3'b100, 5'(addr)};
        #1;
        chk($sformatf("rd[%0d]", addr), uo_out, 8'(exp));
        chk("uio_out", uio_out, 8'h00);
        chk("uio_oe", uio_oe, 8'h00);
        uio_in = '0;
    endtask

    task automatic rd_all();
        for (int i = 0; i < 32; i++) rd(i, mem[i]);
    endtask

    task automatic cyc(int a, int b, bit st, bit cl, bit rs);
        ui_in = {4'(b), 4'(a)};
        uio_in = {1'b0, cl, st, 5'd0};
        rst_n = rs;
        @(posedge clk);
        if (rs) begin
            for (int i = 0; i < 32; i++) mem[i] = 0;
            wp = 0;
        end else begin
            if (st) begin
                mem[wp] = ref_p(a, b);
                wp = (wp + 1) % 32;
            end
            if (cl) wp = 0;
        end
        #1;
        uio_in = '0;
        rst_n = 1'b0;
    endtask

    initial begin
        int old_wp, a, b;
        #2;
        prod(3, 2, 6);
        prod(1, 2, 2);
        prod(0, 9, 0);
        prod(8, 1, 10);
        prod(15, 15, 196);
        prod(12, 5, 70);
        prod(9, 9, 100);
        prod(7, 7, 49);
        for (int a2 = 0; a2 < 16; a2++)
            for (int b2 = 0; b2 < 16; b2 += 5) prod(a2, b2, ref_p(a2, b2));

        cyc(0, 0, 0, 0, 1);
        rd_all();

        cyc(3, 2, 1, 0, 0);
        cyc(15, 15, 1, 0, 0);
        rd(0, 6);
        rd(1, 196);
        rd(2, 0);
        rd(31, 0);

        cyc(0, 0, 0, 0, 1);
        for (int i = 0; i < 33; i++) cyc(i & 15, (i >> 4) + 1, 1, 0, 0);
        rd(0, ref_p(0, 3));
        rd(1, ref_p(1, 1));
        rd_all();

        cyc(2, 2, 1, 0, 0);
        cyc(3, 3, 1, 0, 0);
        old_wp = wp;
        cyc(5, 6, 1, 1, 0);
        cyc(9, 9, 1, 0, 0);
        rd(old_wp, 30);
        rd(0, 100);
        rd_all();

        for (int i = 0; i < 300; i++) begin
            a = $urandom_range(15);
            b = $urandom_range(15);
            cyc(a, b, 1'($urandom_range(1)), ($urandom_range(9) == 0), 0);
            a = $urandom_range(15);
            b = $urandom_range(15);
            prod(a, b, ref_p(a, b));
            a = $urandom_range(31);
            rd(a, mem[a]);
        end
        rd_all();

        cyc(4, 4, 1, 0, 0);
        cyc(5, 5, 1, 0, 1);
        for (int i = 0; i < 32; i++) rd(i, 0);
        prod(13, 11, ref_p(13, 11));

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end
endmodule
